// File: rtl/spi_ctrl_master.sv
// SPI initiator: frames WIDTH-bit MSB-first words under one chip select, all CPOL/CPHA modes.
// Latency: first SCLK edge H cycles after cs_n falls; tx_ready only in IDLE/WAIT, so words offered mid-word wait.
module spi_ctrl_master #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 ena,
  input  logic [1:0]           spi_mode,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic                 tx_valid,
  input  logic [WIDTH-1:0]     tx_data,
  input  logic                 tx_last,
  output logic                 tx_ready,
  output logic                 rx_valid,
  output logic [WIDTH-1:0]     rx_data,
  output logic                 busy,
  output logic                 spi_cs_n,
  output logic                 spi_clk,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  localparam int EW = $clog2(2*WIDTH+1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2*WIDTH);
  localparam logic [EW-1:0] FINAL_PRE = EW'(2*WIDTH-1);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, WAIT, TRAIL} state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [EW-1:0]        edge_q, edge_d;
  logic [WIDTH-1:0]     sh_q, sh_d, rx_data_q, rx_data_d;
  logic [1:0]           mode_q, mode_d;
  logic                 last_q, last_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;
  logic                 cs_n_q, cs_n_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 tick, do_edge, sample;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    edge_d     = edge_q;
    sh_d       = sh_q;
    rx_data_d  = rx_data_q;
    mode_d     = mode_q;
    last_d     = last_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    rx_valid_d = 1'b0;
    tx_ready   = 1'b0;
    do_edge    = 1'b0;
    sample     = 1'b0;
    tick       = (cnt_q == div_q);

    case (state_q)
      IDLE: begin
        tx_ready = 1'b1;
        sclk_d   = spi_mode[1];
        cnt_d    = '0;
        edge_d   = '0;
        if (tx_valid) begin
          mode_d  = spi_mode;
          div_d   = clk_div;
          sh_d    = tx_data;
          last_d  = tx_last;
          cs_n_d  = 1'b0;
          state_d = LEAD;
          if (!spi_mode[0]) mosi_d = tx_data[WIDTH-1];
        end
      end
      LEAD: begin
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        do_edge = tick;
        if (tick) state_d = SHIFT;
      end
      SHIFT: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        // After the last edge, one more half-period elapses before leaving SHIFT.
        if (edge_q == LAST_EDGE) begin
          if (cnt_q == '0) begin
            rx_valid_d = 1'b1;
            rx_data_d  = sh_q;
          end
          if (tick) begin
            edge_d  = '0;
            state_d = last_q ? TRAIL : WAIT;
          end
        end else begin
          do_edge = tick;
        end
      end
      WAIT: begin
        tx_ready = 1'b1;
        cnt_d    = '0;
        if (tx_valid) begin
          sh_d    = tx_data;
          last_d  = tx_last;
          state_d = LEAD;
          if (!mode_q[0]) mosi_d = tx_data[WIDTH-1];
        end
      end
      TRAIL: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
          if (!cs_n_q) cs_n_d = 1'b1;
          else         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Odd edges (edge_q even) are leading; sampling happens on leading edges for CPHA=0, trailing for CPHA=1.
    if (do_edge) begin
      sclk_d = ~sclk_q;
      edge_d = edge_q + 1'b1;
      sample = ~edge_q[0] ^ mode_q[0];
      if (sample)                   sh_d   = {sh_q[WIDTH-2:0], spi_miso};
      else if (edge_q != FINAL_PRE) mosi_d = sh_q[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      edge_q     <= '0;
      sh_q       <= '0;
      rx_data_q  <= '0;
      mode_q     <= '0;
      last_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rx_valid_q <= 1'b0;
    end else if (ena) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      edge_q     <= edge_d;
      sh_q       <= sh_d;
      rx_data_q  <= rx_data_d;
      mode_q     <= mode_d;
      last_q     <= last_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign spi_cs_n = cs_n_q;
  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_ctrl_master.sv
// Directed bench for spi_ctrl_master: bench-side slave/loopback on MISO, monitors sampled 1ns after each clk rise.
module tb_spi_ctrl_master;

  logic       clk;
  logic       rstb;
  logic       ena;
  logic [1:0] spi_mode;
  logic [7:0] clk_div;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       spi_cs_n;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso;

  logic       loop;
  logic       slave_bit;
  logic [7:0] slave_word;
  int         sidx;

  int n_chk;
  int n_fail;

  int         cyc;
  logic       sclk_prev, cs_prev;
  int         rises, edges, last_edge, min_sp, max_sp;
  logic [7:0] mosi_cap, rx_last;
  int         rxv_cnt, csr_cnt, cs_fall_cyc, cs_rise_cyc, rdy_busy;

  assign spi_miso = loop ? spi_mosi : slave_bit;

  spi_ctrl_master #(.WIDTH(8), .DIV_WIDTH(8)) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .spi_mode(spi_mode), .clk_div(clk_div),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .spi_cs_n(spi_cs_n),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rises = 0; edges = 0; last_edge = -1; min_sp = 99999; max_sp = 0;
    mosi_cap = '0; rxv_cnt = 0; csr_cnt = 0; rdy_busy = 0;
    cs_fall_cyc = 0; cs_rise_cyc = 0;
  endtask

  // One clock cycle; all monitoring and the mode-0 slave model live here.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (spi_clk !== sclk_prev) begin
      if (spi_clk) begin
        rises++;
        mosi_cap = {mosi_cap[6:0], spi_mosi};
      end
      if (last_edge >= 0) begin
        if (cyc - last_edge < min_sp) min_sp = cyc - last_edge;
        if (cyc - last_edge > max_sp) max_sp = cyc - last_edge;
      end
      last_edge = cyc;
      edges++;
    end
    if (rx_valid) begin
      rxv_cnt++;
      rx_last = rx_data;
    end
    if (busy && tx_ready) rdy_busy++;
    if (cs_prev && !spi_cs_n) cs_fall_cyc = cyc;
    if (!cs_prev && spi_cs_n) begin
      csr_cnt++;
      cs_rise_cyc = cyc;
    end
    if (spi_cs_n) sidx = 7;
    else if (sclk_prev && !spi_clk) sidx--;
    slave_bit = (sidx >= 0) ? slave_word[sidx[2:0]] : 1'b0;
    sclk_prev = spi_clk;
    cs_prev   = spi_cs_n;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int   n;
    logic ok;
    n = 0;
    tx_valid = 1'b1; tx_data = d; tx_last = last;
    do begin
      ok = tx_ready;
      step();
      n++;
    end while (!ok && n < 200);
    tx_valid = 1'b0;
    chk("accept", {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2000) begin
      step();
      n++;
    end
    chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!tx_ready && n < 200) begin
      step();
      n++;
    end
    chk("ready_timeout", {31'b0, tx_ready}, 32'd1);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    rstb = 1'b0; ena = 1'b1; spi_mode = 2'd0; clk_div = 8'd0;
    tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0;
    loop = 1'b0; slave_word = 8'h3C; slave_bit = 1'b0; sidx = 7;
    sclk_prev = 1'b0; cs_prev = 1'b1; rx_last = '0;
    clr();

    // Reset values
    steps(2);
    chk("rst_cs_n", {31'b0, spi_cs_n}, 32'd1);
    chk("rst_sclk", {31'b0, spi_clk}, 32'd0);
    chk("rst_mosi", {31'b0, spi_mosi}, 32'd0);
    chk("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    chk("rst_rx_data", {24'b0, rx_data}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
    rstb = 1'b1;
    steps(2);

    // Mode 0, H=1, 0xA5 out, slave returns 0x3C
    clr();
    send(8'hA5, 1'b1);
    chk("m0_cs_low_after_accept", {31'b0, spi_cs_n}, 32'd0);
    chk("m0_busy", {31'b0, busy}, 32'd1);
    chk("m0_mosi_msb", {31'b0, spi_mosi}, 32'd1);
    wait_idle();
    chk("m0_mosi_bits", {24'b0, mosi_cap}, 32'hA5);
    chk("m0_rises", rises, 8);
    chk("m0_rxv_cnt", rxv_cnt, 1);
    chk("m0_rx_data", {24'b0, rx_last}, 32'h3C);
    chk("m0_frame_len", cs_rise_cyc - cs_fall_cyc + 1, 19);
    chk("m0_spacing_min", min_sp, 1);
    chk("m0_spacing_max", max_sp, 1);
    chk("m0_rx_hold", {24'b0, rx_data}, 32'h3C);

    // All modes, H=4, loopback 0x81
    loop = 1'b1;
    for (int m = 0; m < 4; m++) begin
      spi_mode = 2'(m);
      clk_div  = 8'd3;
      steps(2);
      chk("modes_sclk_idle_before", {31'b0, spi_clk}, {31'b0, spi_mode[1]});
      clr();
      send(8'h81, 1'b1);
      wait_idle();
      chk("modes_rx", {24'b0, rx_last}, 32'h81);
      chk("modes_edges", edges, 16);
      chk("modes_sp_min", min_sp, 4);
      chk("modes_sp_max", max_sp, 4);
      chk("modes_sclk_idle_after", {31'b0, spi_clk}, {31'b0, spi_mode[1]});
    end

    // Three-word frame with a 10-cycle gap before word 2
    spi_mode = 2'd0; clk_div = 8'd0;
    steps(2);
    clr();
    send(8'h01, 1'b0);
    chk("mw_ready_low_in_lead", {31'b0, tx_ready}, 32'd0);
    wait_ready();
    chk("mw_wait_cs", {31'b0, spi_cs_n}, 32'd0);
    chk("mw_wait_sclk", {31'b0, spi_clk}, 32'd0);
    chk("mw_word1", {24'b0, rx_data}, 32'h01);
    steps(10);
    chk("mw_gap_cs", {31'b0, spi_cs_n}, 32'd0);
    chk("mw_gap_ready", {31'b0, tx_ready}, 32'd1);
    send(8'h02, 1'b0);
    wait_ready();
    chk("mw_word2", {24'b0, rx_data}, 32'h02);
    send(8'h03, 1'b1);
    wait_idle();
    chk("mw_rxv_cnt", rxv_cnt, 3);
    chk("mw_cs_rises", csr_cnt, 1);
    chk("mw_word3", {24'b0, rx_last}, 32'h03);
    chk("mw_ready_busy_cycles", rdy_busy, 12);

    // clk_div change mid-frame takes effect only on the next frame
    clr();
    send(8'h96, 1'b1);
    steps(4);
    clk_div = 8'd7;
    wait_idle();
    chk("div_mid_sp_min", min_sp, 1);
    chk("div_mid_sp_max", max_sp, 1);
    chk("div_mid_rx", {24'b0, rx_last}, 32'h96);
    clr();
    send(8'h69, 1'b1);
    wait_idle();
    chk("div_next_sp_min", min_sp, 8);
    chk("div_next_sp_max", max_sp, 8);
    chk("div_next_rx", {24'b0, rx_last}, 32'h69);
    chk("div_next_len", cs_rise_cyc - cs_fall_cyc + 1, 145);

    // ena low for 5 cycles during SHIFT, H=4, loopback 0x5A
    clk_div = 8'd3;
    steps(2);
    clr();
    send(8'h5A, 1'b1);
    steps(9);
    ena = 1'b0;
    steps(5);
    chk("ena_sclk_frozen", {31'b0, spi_clk}, 32'd0);
    chk("ena_mosi_frozen", {31'b0, spi_mosi}, 32'd1);
    chk("ena_edges_frozen", edges, 2);
    chk("ena_busy", {31'b0, busy}, 32'd1);
    ena = 1'b1;
    wait_idle();
    chk("ena_rx", {24'b0, rx_last}, 32'h5A);
    chk("ena_edges_total", edges, 16);

    // Reset pulse during SHIFT
    clk_div = 8'd0;
    steps(2);
    clr();
    send(8'hF0, 1'b1);
    steps(5);
    rstb = 1'b0;
    #1;
    chk("rst_mid_cs_n", {31'b0, spi_cs_n}, 32'd1);
    chk("rst_mid_sclk", {31'b0, spi_clk}, 32'd0);
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    steps(2);
    chk("rst_mid_no_rxv", rxv_cnt, 0);
    rstb = 1'b1;
    steps(2);
    clr();
    send(8'hC3, 1'b1);
    wait_idle();
    chk("rst_after_rx", {24'b0, rx_last}, 32'hC3);
    chk("rst_after_rxv", rxv_cnt, 1);
    chk("rst_after_cs_rises", csr_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
